// File: rtl/dma_bus_sequencer.sv
// Arbitrates CPU and bus/DMA access to local memory and sequences the bus handshake.
// Optional BWAIT watchdog is built when DMA_WATCHDOG_EN is defined.
module dma_bus_sequencer #(
    parameter int D50 = 2,
    parameter int TMO = 64
) (
    input  logic sysclk,
    input  logic sys_rst,
    input  logic cpu_req,
    input  logic bus_req,
    input  logic bdap,
    input  logic mwrite_n,
    output logic cgnt_n,
    output logic bgnt_n,
    output logic bgnt50_n,
    output logic bdap50_n,
    output logic gnt_n,
    output logic bact,
    output logic wr_lat,
    output logic timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU,
        S_BADR,
        S_BWAIT,
        S_BDATA,
        S_REL
    } state_t;

    localparam logic [3:0] LP_D50 = 4'(D50);

    if (D50 < 1 || D50 > 15 || TMO < 2 || TMO > 255) begin : g_param_err
        $error("dma_bus_sequencer: D50 or TMO out of range");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_last_bus;
    logic       w_last_bus_nxt;
    logic       w_pick_bus;
    logic       w_bus_nxt;
    logic       w_wd_hit;

    logic       r_cgnt_n;
    logic       r_bgnt_n;
    logic       r_bgnt50_n;
    logic       r_bdap50_n;
    logic       r_gnt_n;
    logic       r_bact;
    logic       r_wr_lat;
    logic       w_cgnt_n_nxt;
    logic       w_bgnt_n_nxt;
    logic       w_bgnt50_n_nxt;
    logic       w_bdap50_n_nxt;
    logic       w_wr_lat_nxt;

    // Bus wins a tie unless it was the last requester served.
    assign w_pick_bus = bus_req && (!cpu_req || !r_last_bus);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_bus_nxt = r_last_bus;
        unique case (r_state)
            S_IDLE: begin
                if (w_pick_bus) begin
                    w_state_nxt    = S_BADR;
                    w_cnt_nxt      = LP_D50;
                    w_last_bus_nxt = 1'b1;
                end else if (cpu_req) begin
                    w_state_nxt    = S_CPU;
                    w_last_bus_nxt = 1'b0;
                end
            end
            S_CPU: begin
                if (!cpu_req) begin
                    w_state_nxt = S_REL;
                end
            end
            S_BADR: begin
                if (!bus_req) begin
                    w_state_nxt = S_REL;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_BWAIT;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_BWAIT: begin
                if (!bus_req) begin
                    w_state_nxt = S_REL;
                end else if (bdap) begin
                    w_state_nxt = S_BDATA;
                    w_cnt_nxt   = LP_D50;
                end else if (w_wd_hit) begin
                    w_state_nxt = S_REL;
                end
            end
            S_BDATA: begin
                if (!bdap) begin
                    w_state_nxt = S_REL;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_REL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output values are derived from the next state so every output is a flop.
    always_comb begin
        w_bus_nxt      = (w_state_nxt == S_BADR) ||
                         (w_state_nxt == S_BWAIT) ||
                         (w_state_nxt == S_BDATA);
        w_cgnt_n_nxt   = (w_state_nxt != S_CPU);
        w_bgnt_n_nxt   = !w_bus_nxt;
        w_bgnt50_n_nxt = !((w_state_nxt == S_BWAIT) ||
                           (w_state_nxt == S_BDATA));
        w_bdap50_n_nxt = 1'b1;
        if ((w_state_nxt == S_BDATA) && (r_state == S_BDATA) &&
            ((r_cnt == 4'd1) || !r_bdap50_n)) begin
            w_bdap50_n_nxt = 1'b0;
        end
        w_wr_lat_nxt = 1'b0;
        if ((r_state == S_IDLE) && (w_state_nxt == S_BADR)) begin
            w_wr_lat_nxt = !mwrite_n;
        end else if (w_bus_nxt) begin
            w_wr_lat_nxt = r_wr_lat;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_last_bus <= 1'b0;
            r_cgnt_n   <= 1'b1;
            r_bgnt_n   <= 1'b1;
            r_bgnt50_n <= 1'b1;
            r_bdap50_n <= 1'b1;
            r_gnt_n    <= 1'b1;
            r_bact     <= 1'b0;
            r_wr_lat   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_bus <= w_last_bus_nxt;
            r_cgnt_n   <= w_cgnt_n_nxt;
            r_bgnt_n   <= w_bgnt_n_nxt;
            r_bgnt50_n <= w_bgnt50_n_nxt;
            r_bdap50_n <= w_bdap50_n_nxt;
            r_gnt_n    <= w_cgnt_n_nxt & w_bgnt_n_nxt;
            r_bact     <= w_bus_nxt;
            r_wr_lat   <= w_wr_lat_nxt;
        end
    end

`ifdef DMA_WATCHDOG_EN
    localparam logic [7:0] LP_TMO_LAST = 8'(TMO - 1);

    logic [7:0] r_wd;
    logic       r_timeout;

    assign w_wd_hit = (r_state == S_BWAIT) && (r_wd == LP_TMO_LAST);

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_wd      <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wd_hit && bus_req && !bdap;
            if ((r_state == S_BWAIT) && (w_state_nxt == S_BWAIT)) begin
                r_wd <= r_wd + 8'd1;
            end else begin
                r_wd <= 8'd0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wd_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign cgnt_n   = r_cgnt_n;
    assign bgnt_n   = r_bgnt_n;
    assign bgnt50_n = r_bgnt50_n;
    assign bdap50_n = r_bdap50_n;
    assign gnt_n    = r_gnt_n;
    assign bact     = r_bact;
    assign wr_lat   = r_wr_lat;

endmodule

// File: doc/dma_bus_sequencer.md
DMA_BUS_SEQUENCER -- requirements
Module: dma_bus_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of sysclk.
REQ-002 Parameter D50, default 2, SHALL set the cycles from bus-grant to bgnt50_n, and from bdap to bdap50_n (range 1..15).
REQ-003 Parameter TMO, default 64, SHALL set the BWAIT watchdog limit in cycles (range 2..255).
REQ-004 Port sysclk  in  1  system clock.
REQ-005 Port sys_rst  in  1  synchronous active-high reset.
REQ-006 Port cpu_req  in  1  CPU requests local memory; high = request.
REQ-007 Port bus_req  in  1  bus/DMA address present (BAPR), synchronised; high = request.
REQ-008 Port bdap  in  1  bus data present, synchronised; high = data valid.
REQ-009 Port mwrite_n  in  1  DMA direction, sampled at bus grant; low = write.
REQ-010 Port cgnt_n  out  1  CPU grant, active low.
REQ-011 Port bgnt_n  out  1  bus grant, active low.
REQ-012 Port bgnt50_n  out  1  delayed bus grant, active low.
REQ-013 Port bdap50_n  out  1  delayed data-present strobe, active low.
REQ-014 Port gnt_n  out  1  low whenever cgnt_n or bgnt_n is low.
REQ-015 Port bact  out  1  bus cycle in progress (BADR, BWAIT or BDATA).
REQ-016 Port wr_lat  out  1  latched mwrite_n inverted; high = current bus cycle is a write.
REQ-017 Port timeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-018 FSM states SHALL be IDLE, CPU, BADR, BWAIT, BDATA and REL; all outputs SHALL be registered.
REQ-019 In IDLE, a single requester SHALL be granted on the next edge: cpu_req -> CPU, bus_req -> BADR.
REQ-020 When both requests are high in IDLE, the requester not served last SHALL win; after reset the last-served flag SHALL be CPU, so bus wins the first tie.
REQ-021 In CPU, cgnt_n SHALL be 0 and SHALL hold while cpu_req is 1; cpu_req low SHALL move the FSM to REL.
REQ-022 On entering BADR, bgnt_n SHALL go 0, wr_lat SHALL capture ~mwrite_n, and the delay counter SHALL load D50.
REQ-023 bgnt50_n SHALL go 0 exactly D50 cycles after bgnt_n goes 0; BADR SHALL then advance to BWAIT.
REQ-024 In BWAIT, bdap sampled 1 SHALL move to BDATA and reload the counter; bdap50_n SHALL go 0 D50 cycles later.
REQ-025 In BDATA, bdap sampled 0 SHALL move to REL; if bdap falls before bdap50_n has asserted, bdap50_n SHALL stay 1 for that cycle.
REQ-026 bus_req falling in BADR or BWAIT SHALL abort to REL with no bdap50_n pulse.
REQ-027 In REL, all grant and strobe outputs SHALL be 1 and bact SHALL be 0 for exactly one cycle; REL SHALL then return to IDLE and ignore requests during that cycle.
REQ-028 gnt_n SHALL equal cgnt_n AND bgnt_n in every cycle; cgnt_n and bgnt_n SHALL never be 0 together.
REQ-029 The last-served flag SHALL update on entry to CPU or BADR.

Reset
REQ-030 sys_rst=1 at an edge SHALL force IDLE from any state, including mid-cycle, and the next cycle SHALL show cgnt_n=bgnt_n=bgnt50_n=bdap50_n=gnt_n=1, bact=wr_lat=timeout=0, counters=0 and last-served=CPU.

Configuration
REQ-031 With macro DMA_WATCHDOG_EN defined, a counter SHALL run in BWAIT; reaching TMO cycles without bdap SHALL pulse timeout for 1 cycle and enter REL.
REQ-032 Without DMA_WATCHDOG_EN, BWAIT SHALL wait indefinitely, timeout SHALL be tied 0, and no watchdog counter SHALL be instantiated.

Verification
REQ-033 cpu_req=1 for 5 cycles, then 0 -> cgnt_n low 5 cycles, then 1 REL cycle, then IDLE; bgnt_n stays 1.
REQ-034 D50=2, bus_req=1, mwrite_n=0, bdap=1 at grant+4 for 3 cycles -> bgnt50_n low at grant+2, bdap50_n low 2 cycles after bdap sampled, wr_lat=1, REL after bdap falls.
REQ-035 cpu_req and bus_req rise together twice, served in between -> first bus grant, then CPU grant.
REQ-036 DMA_WATCHDOG_EN, TMO=8, bus grant with bdap held 0 -> timeout pulses once 8 cycles into BWAIT, then REL and IDLE; with the macro undefined, the FSM stays in BWAIT.
REQ-037 sys_rst asserted in BDATA with bdap50_n=0 -> all outputs return to reset values at the next edge; a tie afterwards grants the bus.
